// File: rtl/regfile_dma_pkg.sv
// Shared sizes, op codes and FSM state type for the register file save/restore sequencer.
// Define REGFILE_DMA_CHECKSUM_EN to add the XOR checksum beat to both streams.
package regfile_dma_pkg;
    localparam int N_W = 16;
    localparam int R_W = 4;

    localparam logic OP_SAVE    = 1'b0;
    localparam logic OP_RESTORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        RESTORE
    } state_e;
endpackage

// File: rtl/regfile_dma_if.sv
// Command, register file and stream signals of regfile_dma.
// slave is the sequencer's view; master is the core/host side.
interface regfile_dma_if;
    import regfile_dma_pkg::*;

    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_op;
    logic [R_W-1:0] cmd_first;
    logic [R_W-1:0] cmd_last;
    logic [R_W-1:0] rf_ra;
    logic [N_W-1:0] rf_rd;
    logic           rf_we;
    logic [R_W-1:0] rf_wa;
    logic [N_W-1:0] rf_wd;
    logic           out_valid;
    logic           out_ready;
    logic [N_W-1:0] out_data;
    logic           out_last;
    logic           in_valid;
    logic           in_ready;
    logic [N_W-1:0] in_data;
    logic           busy;
    logic           done;
    logic           err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_first, cmd_last, rf_rd,
        input  out_ready, in_valid, in_data,
        output cmd_ready, rf_ra, rf_we, rf_wa, rf_wd,
        output out_valid, out_data, out_last, in_ready,
        output busy, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_first, cmd_last, rf_rd,
        output out_ready, in_valid, in_data,
        input  cmd_ready, rf_ra, rf_we, rf_wa, rf_wd,
        input  out_valid, out_data, out_last, in_ready,
        input  busy, done, err
    );
endinterface

// File: rtl/regfile_dma_obuf.sv
// One-entry valid/ready output register carrying data and last.
// Caller only asserts load when the entry is empty or draining.
module regfile_dma_obuf
    import regfile_dma_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [N_W-1:0] ld_data,
    input  logic           ld_last,
    input  logic           ready,
    output logic           valid,
    output logic [N_W-1:0] data,
    output logic           last
);
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic [N_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q && !ready;
        data_d  = data_q;
        last_d  = last_q && valid_d;
        if (load) begin
            valid_d = 1'b1;
            data_d  = ld_data;
            last_d  = ld_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign last  = last_q;
endmodule

// File: rtl/regfile_dma.sv
// Register file save/restore sequencer walking a wrapping address range.
// REGFILE_DMA_CHECKSUM_EN appends/checks an XOR checksum beat.
module regfile_dma
    import regfile_dma_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    regfile_dma_if.slave bus
);
`ifdef REGFILE_DMA_CHECKSUM_EN
    localparam logic CK_EN = 1'b1;
`else
    localparam logic CK_EN = 1'b0;
`endif
    localparam logic [R_W:0]   REM_ONE = {{R_W{1'b0}}, 1'b1};
    localparam logic [R_W-1:0] CUR_ONE = {{(R_W-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [R_W-1:0] cur_q, cur_d;
    logic [R_W:0]   rem_q, rem_d;
    logic           done_q, done_d;

    logic           ob_load, ob_ld_last, ob_valid, ob_last;
    logic [N_W-1:0] ob_ld_data, ob_data;
    logic [R_W-1:0] ra, wa;
    logic [N_W-1:0] wd;
    logic           we, in_rdy;

`ifdef REGFILE_DMA_CHECKSUM_EN
    logic [N_W-1:0] csum_q, csum_d;
    logic           tail_q, tail_d;
    logic           err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        ob_load    = 1'b0;
        ob_ld_data = bus.rf_rd;
        ob_ld_last = 1'b0;
        ra         = '0;
        we         = 1'b0;
        wa         = '0;
        wd         = '0;
        in_rdy     = 1'b0;
`ifdef REGFILE_DMA_CHECKSUM_EN
        csum_d = csum_q;
        tail_d = tail_q;
        err_d  = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cur_d   = bus.cmd_first;
                    rem_d   = {1'b0, bus.cmd_last - bus.cmd_first} + REM_ONE;
                    state_d = (bus.cmd_op == OP_RESTORE) ? RESTORE : SAVE;
`ifdef REGFILE_DMA_CHECKSUM_EN
                    csum_d = '0;
                    tail_d = 1'b1;
                    err_d  = 1'b0;
`endif
                end
            end
            SAVE: begin
                ra = cur_q;
                if (ob_valid && bus.out_ready && ob_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                if (!ob_valid || bus.out_ready) begin
                    if (rem_q != '0) begin
                        ob_load    = 1'b1;
                        ob_ld_last = !CK_EN && (rem_q == REM_ONE);
                        cur_d      = cur_q + CUR_ONE;
                        rem_d      = rem_q - REM_ONE;
`ifdef REGFILE_DMA_CHECKSUM_EN
                        csum_d = csum_q ^ bus.rf_rd;
`endif
                    end
`ifdef REGFILE_DMA_CHECKSUM_EN
                    else if (tail_q) begin
                        ob_load    = 1'b1;
                        ob_ld_data = csum_q;
                        ob_ld_last = 1'b1;
                        tail_d     = 1'b0;
                    end
`endif
                end
            end
            RESTORE: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    if (rem_q != '0) begin
                        // r0 is hardwired; its beat is consumed but not written
                        we    = (cur_q != '0);
                        wa    = cur_q;
                        wd    = bus.in_data;
                        cur_d = cur_q + CUR_ONE;
                        rem_d = rem_q - REM_ONE;
`ifdef REGFILE_DMA_CHECKSUM_EN
                        csum_d = csum_q ^ bus.in_data;
`endif
                    end
`ifdef REGFILE_DMA_CHECKSUM_EN
                    else begin
                        err_d = (bus.in_data != csum_q);
                    end
`endif
                    if (CK_EN ? (rem_q == '0) : (rem_q == REM_ONE)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

`ifdef REGFILE_DMA_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
            tail_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    regfile_dma_obuf u_obuf (
        .clk     (clk),
        .rst     (rst),
        .load    (ob_load),
        .ld_data (ob_ld_data),
        .ld_last (ob_ld_last),
        .ready   (bus.out_ready),
        .valid   (ob_valid),
        .data    (ob_data),
        .last    (ob_last)
    );

    assign bus.out_valid = ob_valid;
    assign bus.out_data  = ob_data;
    assign bus.out_last  = ob_last;
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.rf_ra     = ra;
    assign bus.rf_we     = we;
    assign bus.rf_wa     = wa;
    assign bus.rf_wd     = wd;
    assign bus.in_ready  = in_rdy;
endmodule

// File: doc/regfile_dma.md
# regfile_dma

Save/restore sequencer that drives the three-port register file's ports as their initiator: on command it walks a contiguous, wrapping range of register addresses, either reading each register through a read port and streaming the words out (save), or accepting a stream of words and writing them through the write port (restore). It sits beside the core's register file for context switch, debug dump and test preload. While `busy` is high the core is stalled and this block has exclusive access to one read port and the write port.

## Interface
- `n`, 16, register width in bits
- `r`, 4, register address width; 2**r registers
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_op`  in  1  0 = SAVE, 1 = RESTORE
- `cmd_first`  in  r  first register address
- `cmd_last`  in  r  last register address, inclusive, may be below `cmd_first` (wraps)
- `rf_ra`  out  r  register file read address
- `rf_rd`  in  n  register file read data, combinational from `rf_ra`
- `rf_we`, `rf_wa`, `rf_wd`  out  1 / r / n  register file write enable, address, data
- `out_valid`, `out_ready`, `out_data`, `out_last`  out/in/out/out  1/1/n/1  save stream
- `in_valid`, `in_ready`, `in_data`  in/out/in  1/1/n  restore stream
- `busy`  out  1  high in any state but IDLE
- `done`  out  1  one-cycle pulse after the final beat transfers
- `err`  out  1  checksum mismatch flag (see Configuration)

## Operation
- States: IDLE, SAVE, RESTORE. Command handshake `cmd_valid && cmd_ready` latches op, `cur <= cmd_first`, `remaining <= ((cmd_last - cmd_first) mod 2**r) + 1`, then enters SAVE or RESTORE.
- Beat count: `first == last` -> 1 beat; `first == last + 1 (mod 2**r)` -> all 2**r registers. `cur` wraps from 2**r-1 to 0.
- `remaining` is r+1 bits wide.
- SAVE: `rf_ra = cur`. One-entry output register; loads `rf_rd` whenever it is empty or drains this cycle (`out_valid && out_ready`), then `cur++`, `remaining--`. `out_last` set with the final data beat. Register 0 is read as-is (reads 0).
- RESTORE: `in_ready = 1`. Each `in_valid && in_ready` drives `rf_we = 1`, `rf_wa = cur`, `rf_wd = in_data` combinationally, then `cur++`, `remaining--`. Beat addressed to register 0 is consumed with `rf_we = 0`.
- Final beat transfer: `done` pulses next cycle, state returns to IDLE on the same edge as the transfer.
- `out_data` held stable while `out_valid && !out_ready`; `out_valid` never drops without a transfer.
- Outside RESTORE, `rf_we = 0`; `rf_wa`, `rf_wd` = 0. Outside SAVE, `rf_ra` = 0.

## Timing
- Reset values: `cmd_ready` 1 once reset deasserts; `busy`, `done`, `err`, `out_valid`, `out_last`, `rf_we`, `in_ready` 0; `out_data`, `rf_ra`, `rf_wa`, `rf_wd` 0.
- Command accepted at edge k: `busy` from k; first `out_valid` after edge k+1; with `out_ready` held high, one beat per cycle, N beats end at edge k+N.
- Restore: zero latency from input beat to register write (same edge); one beat per cycle.
- Backpressure on either stream stalls the walk without loss or duplication.
- `rst` mid-operation: immediate return to IDLE, stream dropped, registers already written stay written; no `done`.

## Configuration
- `REGFILE_DMA_CHECKSUM_EN` defined: running XOR of all data beats. SAVE appends one extra beat carrying the checksum; `out_last` moves to it. RESTORE consumes one extra beat after the data, never writes it, sets `err` if it differs from the computed XOR. `err` is sticky until the next accepted command.
- Undefined: no extra beat, no checksum logic, `err` tied 0.

## Structure
- `regfile_dma_pkg`: state enum (IDLE, SAVE, RESTORE), op constants `OP_SAVE = 1'b0`, `OP_RESTORE = 1'b1`.
- One sub-module: `regfile_dma_obuf`, the one-entry valid/ready output register with data and last.

## Test plan
- Reset, then SAVE first=1 last=3 with regfile r1..r3 = 0x1111, 0x2222, 0x3333, `out_ready` high -> beats 0x1111, 0x2222, 0x3333 on consecutive cycles, `out_last` on 0x3333, `done` one cycle later.
- RESTORE first=14 last=1, inputs 0xA, 0xB, 0xC, 0xD -> writes r14=0xA, r15=0xB, r0 skipped (`rf_we` 0), r1=0xD.
- SAVE first=5 last=4 with `out_ready` toggling every cycle -> all 16 beats in address order 5..15, 0..4, none dropped or repeated, data stable while stalled.
- SAVE in progress, assert `rst` after beat 2 -> next cycle `busy` 0, `out_valid` 0, `cmd_ready` 1, no `done`.
- With `REGFILE_DMA_CHECKSUM_EN`: RESTORE first=2 last=3, beats 0x00F0, 0x0F00, checksum 0x0FF1 -> r2, r3 written, `err` 1; repeat with checksum 0x0FF0 -> `err` 0.
